// File: rtl/alu_arbiter_if.sv
// Bundle of requester, ALU-side and response signals around the shared ALU arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface alu_arbiter_if #(
  parameter int SIZE = 32
);
  logic            req0_valid_i;
  logic            req0_ready_o;
  logic [2:0]      req0_f3_i;
  logic [6:0]      req0_f7_i;
  logic [SIZE-1:0] req0_op1_i;
  logic [SIZE-1:0] req0_op2_i;
  logic            req1_valid_i;
  logic            req1_ready_o;
  logic [2:0]      req1_f3_i;
  logic [6:0]      req1_f7_i;
  logic [SIZE-1:0] req1_op1_i;
  logic [SIZE-1:0] req1_op2_i;
  logic [2:0]      alu_f3_o;
  logic [6:0]      alu_f7_o;
  logic [SIZE-1:0] alu_op1_o;
  logic [SIZE-1:0] alu_op2_o;
  logic [SIZE-1:0] alu_res_i;
  logic            rsp_valid_o;
  logic            rsp_id_o;
  logic [SIZE-1:0] rsp_data_o;
  logic            rsp_ready_i;

  modport slave (
    input  req0_valid_i, req0_f3_i, req0_f7_i, req0_op1_i, req0_op2_i,
    input  req1_valid_i, req1_f3_i, req1_f7_i, req1_op1_i, req1_op2_i,
    output req0_ready_o, req1_ready_o,
    output alu_f3_o, alu_f7_o, alu_op1_o, alu_op2_o,
    input  alu_res_i,
    output rsp_valid_o, rsp_id_o, rsp_data_o,
    input  rsp_ready_i
  );

  modport master (
    output req0_valid_i, req0_f3_i, req0_f7_i, req0_op1_i, req0_op2_i,
    output req1_valid_i, req1_f3_i, req1_f7_i, req1_op1_i, req1_op2_i,
    input  req0_ready_o, req1_ready_o,
    input  alu_f3_o, alu_f7_o, alu_op1_o, alu_op2_o,
    output alu_res_i,
    input  rsp_valid_o, rsp_id_o, rsp_data_o,
    output rsp_ready_i
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Optional macro ALU_ARB_PIPE_EN overlaps the next grant with the response handshake.
module alu_arbiter #(
  parameter int SIZE = 32
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e          state_q, state_d;
  logic [2:0]      f3_q, f3_d;
  logic [6:0]      f7_q, f7_d;
  logic [SIZE-1:0] op1_q, op1_d;
  logic [SIZE-1:0] op2_q, op2_d;
  logic [SIZE-1:0] data_q, data_d;
  logic            id_q, id_d;
  logic            last_q, last_d;
  logic            grant_en, sel1, rdy0, rdy1, accept;

  always_comb begin
    grant_en = (state_q == IDLE);
`ifdef ALU_ARB_PIPE_EN
    grant_en = grant_en || ((state_q == RESP) && bus.rsp_ready_i);
`endif
    // On a tie, the requester that did not win last time is served.
    sel1   = bus.req1_valid_i && (!bus.req0_valid_i || !last_q);
    rdy0   = grant_en && bus.req0_valid_i && !sel1;
    rdy1   = grant_en && sel1;
    accept = rdy0 || rdy1;

    state_d = state_q;
    f3_d    = f3_q;
    f7_d    = f7_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    data_d  = data_q;
    id_d    = id_q;
    last_d  = last_q;

    case (state_q)
      IDLE: if (accept) state_d = EXEC;
      EXEC: begin
        data_d  = bus.alu_res_i;
        state_d = RESP;
      end
      RESP: if (bus.rsp_ready_i) state_d = accept ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      f3_d   = sel1 ? bus.req1_f3_i  : bus.req0_f3_i;
      f7_d   = sel1 ? bus.req1_f7_i  : bus.req0_f7_i;
      op1_d  = sel1 ? bus.req1_op1_i : bus.req0_op1_i;
      op2_d  = sel1 ? bus.req1_op2_i : bus.req0_op2_i;
      id_d   = sel1;
      last_d = sel1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      f3_q    <= '0;
      f7_q    <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      data_q  <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      f7_q    <= f7_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      data_q  <= data_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  // Ready is masked while reset is held; the mask stays off the state path.
  assign bus.req0_ready_o = rdy0 && !rst;
  assign bus.req1_ready_o = rdy1 && !rst;
  assign bus.alu_f3_o     = f3_q;
  assign bus.alu_f7_o     = f7_q;
  assign bus.alu_op1_o    = op1_q;
  assign bus.alu_op2_o    = op2_q;
  assign bus.rsp_valid_o  = (state_q == RESP);
  assign bus.rsp_id_o     = id_q;
  assign bus.rsp_data_o   = data_q;

endmodule
